signal_measure: RTL and testbench
=================================

SIGNAL_MEASURE -- requirements
Module: signal_measure

Interface
REQ-001 SHALL have parameter CNT_W, default 24, giving the width of the period/high-time accumulators.
REQ-002 SHALL have port Clk, input, 1, the single system clock; all logic on its rising edge.
REQ-003 SHALL have port Rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port SignalIn, input, 1, measured signal, asynchronous to Clk.
REQ-005 SHALL have port Start, input, 1, one-cycle request to begin a measurement.
REQ-006 SHALL have port AvgSel, input, 2, number of periods accumulated (0/1/2/3 -> 1/2/4/8), sampled on accepted Start.
REQ-007 SHALL have port PeriodCount, output, CNT_W, total Clk cycles spanned by the accumulated periods.
REQ-008 SHALL have port HighCount, output, CNT_W, Clk cycles SignalIn was high within the same window.
REQ-009 SHALL have port Valid, output, 1, one-cycle pulse when PeriodCount/HighCount update.
REQ-010 SHALL have port Busy, output, 1, high while a measurement is in progress.
REQ-011 SHALL have port Timeout, output, 1, one-cycle pulse when a measurement is abandoned.

Function
REQ-012 SHALL pass SignalIn through a 2-flop synchronizer, then a delay flop; a rising edge is synced=1 and delayed=0 (3-cycle constant latency, cancels in all counts).
REQ-013 SHALL implement FSM IDLE -> ARM -> MEASURE -> DONE -> IDLE.
REQ-014 IDLE: Start=1 -> ARM, latch AvgSel, clear working counters; Start in any other state ignored.
REQ-015 ARM: first detected rising edge (cycle t0) -> MEASURE, working period counter=0, periods-seen=0.
REQ-016 MEASURE: period counter +1 every cycle; high counter +1 for every cycle in [t0, t_end-1] with synced level=1.
REQ-017 MEASURE: each detected rising edge increments periods-seen; when it reaches 2^AvgSel (cycle t_end) -> DONE.
REQ-018 Period of P clocks, H high, AvgSel=0 SHALL yield PeriodCount=P, HighCount=H; AvgSel=k yields sums over 2^k consecutive periods.
REQ-019 DONE: load PeriodCount/HighCount from working counters, Valid=1 for exactly one cycle, -> IDLE; Start in this cycle ignored.
REQ-020 Outputs SHALL hold last valid values until the next Valid; never change otherwise.
REQ-021 Busy SHALL be 1 in ARM and MEASURE, 0 in IDLE and DONE.
REQ-022 ARM or MEASURE: if working period counter reaches 2^CNT_W-1 (no edge/too slow) -> Timeout=1 one cycle, -> IDLE, outputs unchanged.
REQ-023 Counters SHALL never wrap; the timeout check pre-empts overflow.
REQ-024 Edge on the same cycle as the timeout threshold: timeout wins.
REQ-025 Constant-level or DC input SHALL always end in Timeout, never Valid.

Reset
REQ-026 Rst=1 SHALL asynchronously force state IDLE, all synchronizer/working registers 0, PeriodCount=0, HighCount=0, Valid=0, Busy=0, Timeout=0.
REQ-027 Reset mid-measurement SHALL discard it with no Valid or Timeout; a fresh Start is required afterwards.

Structure
REQ-028 Shared package SHALL hold state encodings, CNT_W default and the AvgSel-to-period-count mapping.
REQ-029 Synchronizer and edge detector SHALL be one sub-module, edge_sync (outputs level and rise pulse).

Verification
REQ-030 Square wave period 100, high 25 Clk, AvgSel=0, Start -> Valid once, PeriodCount=100, HighCount=25.
REQ-031 Period 37, high 10, AvgSel=3 -> PeriodCount=296, HighCount=80; Busy high from Start+1 until Valid cycle.
REQ-032 SignalIn held 0, CNT_W=8, Start -> Timeout pulse 255 cycles after ARM entry, Busy falls, outputs keep prior values.
REQ-033 Start pulsed again during MEASURE, and in the DONE cycle -> ignored, single Valid, results unchanged from REQ-030 case.
REQ-034 Rst asserted mid-MEASURE -> outputs 0 immediately, no Valid/Timeout; next Start gives correct result.
REQ-035 Input glitch-free but asynchronous (phase swept over 20 runs), period 64 high 32 -> PeriodCount=64 +/-1 and HighCount=32 +/-1 every run.

Source files
------------

// File: rtl/signal_measure_pkg.sv
// Shared definitions for the signal period / high-time measurement block:
// FSM state encoding, default accumulator width and the averaging-select
// to number-of-periods mapping.
package signal_measure_pkg;

  // Default width of the period and high-time accumulators.
  localparam int CNT_W_DEFAULT = 24;

  // Width of the periods-seen counter; must hold the largest period count (8).
  localparam int SEEN_W = 4;

  // Measurement sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // AvgSel 0/1/2/3 selects 1/2/4/8 accumulated periods.
  function automatic logic [SEEN_W-1:0] periods_for(input logic [1:0] avg_sel);
    return 4'd1 << avg_sel;
  endfunction

endpackage

// File: rtl/signal_measure_edge_sync.sv
// Purpose: two-flop synchronizer for an asynchronous input plus a delay flop for rise detection.
// Latency: level_o lags the input by 2 cycles, rise_o pulses 2 cycles after a rising input edge.
// Backpressure: none; free-running, one rise pulse per synchronized rising edge.
module edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic dly_q;

  // Metastability filter followed by a one-cycle delayed copy for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  assign level_o = sync2_q;
  assign rise_o  = sync2_q & ~dly_q;

endmodule

// File: rtl/signal_measure.sv
// Purpose: measures period and high time of an asynchronous input, summed over 1/2/4/8 periods.
// Latency: result Valid one cycle after the closing synchronized rising edge; sync delay cancels.
// Backpressure: none; Start outside IDLE is ignored, stuck inputs end in a Timeout pulse.
module signal_measure
  import signal_measure_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             SignalIn,
  input  logic             Start,
  input  logic [1:0]       AvgSel,
  output logic [CNT_W-1:0] PeriodCount,
  output logic [CNT_W-1:0] HighCount,
  output logic             Valid,
  output logic             Busy,
  output logic             Timeout
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              sig_level;
  logic              sig_rise;

  state_t            state_q;
  logic [1:0]        avg_q;
  logic [CNT_W-1:0]  per_q;
  logic [CNT_W-1:0]  per_d;
  logic [CNT_W-1:0]  high_q;
  logic [CNT_W-1:0]  high_d;
  logic [SEEN_W-1:0] seen_q;
  logic [SEEN_W-1:0] seen_d;
  logic [CNT_W-1:0]  per_out_q;
  logic [CNT_W-1:0]  high_out_q;
  logic              valid_q;
  logic              busy_q;
  logic              timeout_q;
  logic              at_limit;
  logic              last_edge;

  edge_sync u_edge_sync (
    .clk_i   (Clk),
    .rst_i   (Rst),
    .async_i (SignalIn),
    .level_o (sig_level),
    .rise_o  (sig_rise)
  );

  // Next values of the working counters; the limit check looks at the value
  // the period counter would take so it can never wrap past all-ones.
  always_comb begin
    per_d     = per_q + CNT_ONE;
    high_d    = sig_level ? (high_q + CNT_ONE) : high_q;
    seen_d    = seen_q + 4'd1;
    at_limit  = (per_d == CNT_MAX);
    last_edge = sig_rise && (seen_d == periods_for(avg_q));
  end

  // Measurement sequencer with registered result, Valid, Busy and Timeout.
  // The period counter restarts at 0 on the opening edge and then counts every
  // MEASURE cycle including the closing edge, giving exactly t_end - t0 cycles.
  // The high counter samples the same cycles; since the level is 1 on both the
  // opening and closing edge cycles this equals the high cycles in [t0, t_end-1].
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      avg_q      <= 2'd0;
      per_q      <= '0;
      high_q     <= '0;
      seen_q     <= '0;
      per_out_q  <= '0;
      high_out_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            state_q <= ST_ARM;
            avg_q   <= AvgSel;
            per_q   <= '0;
            high_q  <= '0;
            seen_q  <= '0;
            busy_q  <= 1'b1;
          end
        end

        ST_ARM: begin
          // Threshold is checked before the edge so a coincident edge loses.
          if (at_limit) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else if (sig_rise) begin
            state_q <= ST_MEASURE;
            per_q   <= '0;
            high_q  <= '0;
            seen_q  <= '0;
          end else begin
            per_q <= per_d;
          end
        end

        ST_MEASURE: begin
          if (at_limit) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            per_q  <= per_d;
            high_q <= high_d;
            if (sig_rise) begin
              seen_q <= seen_d;
            end
            if (last_edge) begin
              state_q    <= ST_DONE;
              per_out_q  <= per_d;
              high_out_q <= high_d;
              valid_q    <= 1'b1;
              busy_q     <= 1'b0;
            end
          end
        end

        ST_DONE: begin
          // Result is already on the outputs with Valid high; Start is ignored here.
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign PeriodCount = per_out_q;
  assign HighCount   = high_out_q;
  assign Valid       = valid_q;
  assign Busy        = busy_q;
  assign Timeout     = timeout_q;

endmodule

// File: tb/tb_signal_measure.sv
// Directed bench for signal_measure: table of square waves with hand-computed
// sums, plus sequences for timeout, ignored Start, reset abort and phase sweep.
module tb_signal_measure;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        SignalIn = 1'b0;
  logic        Start = 1'b0;
  logic        Start8 = 1'b0;
  logic [1:0]  AvgSel = 2'd0;
  logic [23:0] PeriodCount;
  logic [23:0] HighCount;
  logic        Valid, Busy, Timeout;
  logic [7:0]  PeriodCount8;
  logic [7:0]  HighCount8;
  logic        Valid8, Busy8, Timeout8;

  signal_measure dut (
    .Clk(Clk), .Rst(Rst), .SignalIn(SignalIn), .Start(Start), .AvgSel(AvgSel),
    .PeriodCount(PeriodCount), .HighCount(HighCount),
    .Valid(Valid), .Busy(Busy), .Timeout(Timeout)
  );

  signal_measure #(.CNT_W(8)) dut8 (
    .Clk(Clk), .Rst(Rst), .SignalIn(SignalIn), .Start(Start8), .AvgSel(2'd0),
    .PeriodCount(PeriodCount8), .HighCount(HighCount8),
    .Valid(Valid8), .Busy(Busy8), .Timeout(Timeout8)
  );

  always #50 Clk = ~Clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Event monitor, sampled on the falling edge.
  int v_cnt = 0, t_cnt = 0, v8_cnt = 0, t8_cnt = 0, cyc = 0;
  int cap_per = 0, cap_high = 0, cap8_per = 0, cap8_high = 0;
  int cap_busy = 0, cap_prev_busy = 0;
  int busy8_rise = 0, to8_cyc = 0;
  logic prev_busy = 1'b0, prev_busy8 = 1'b0;

  always @(negedge Clk) begin
    cyc++;
    if (Valid) begin
      v_cnt++;
      cap_per = int'(PeriodCount);
      cap_high = int'(HighCount);
      cap_busy = int'(Busy);
      cap_prev_busy = int'(prev_busy);
    end
    if (Timeout) t_cnt++;
    if (Valid8) begin
      v8_cnt++;
      cap8_per = int'(PeriodCount8);
      cap8_high = int'(HighCount8);
    end
    if (Timeout8) begin
      t8_cnt++;
      to8_cyc = cyc;
    end
    if (Busy8 && !prev_busy8) busy8_rise = cyc;
    prev_busy = Busy;
    prev_busy8 = Busy8;
  end

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total_cnt++;
    if (act >= lo && act <= hi) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic wave(input int period, input int high, input int n);
    repeat (n) begin
      SignalIn = 1'b1;
      tick(high);
      SignalIn = 1'b0;
      tick(period - high);
    end
  endtask

  typedef struct {
    int         period;
    int         high;
    logic [1:0] avg;
    int         exp_per;
    int         exp_high;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input string tag, input vec_t v);
    int v0, t0;
    SignalIn = 1'b0;
    tick(4);
    v0 = v_cnt;
    t0 = t_cnt;
    AvgSel = v.avg;
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
    AvgSel = 2'd0;
    check({tag, " busy_after_start"}, int'(Busy), 1);
    tick(2);
    wave(v.period, v.high, (1 << v.avg) + 1);
    tick(8);
    check({tag, " valid_count"}, v_cnt - v0, 1);
    check({tag, " timeout_count"}, t_cnt - t0, 0);
    check({tag, " period"}, cap_per, v.exp_per);
    check({tag, " high"}, cap_high, v.exp_high);
    check({tag, " busy_before_valid"}, cap_prev_busy, 1);
    check({tag, " busy_in_valid"}, cap_busy, 0);
    check({tag, " period_held"}, int'(PeriodCount), v.exp_per);
  endtask

  initial begin
    int v0, t0, found;
    vecs[0] = '{100, 25, 2'd0, 100, 25};
    vecs[1] = '{37, 10, 2'd3, 296, 80};
    vecs[2] = '{20, 5, 2'd1, 40, 10};
    vecs[3] = '{50, 49, 2'd2, 200, 196};
    vecs[4] = '{2, 1, 2'd2, 8, 4};
    vecs[5] = '{10, 1, 2'd0, 10, 1};
    vecs[6] = '{3, 1, 2'd3, 24, 8};

    // Reset state.
    tick(3);
    check("rst PeriodCount", int'(PeriodCount), 0);
    check("rst HighCount", int'(HighCount), 0);
    check("rst Valid", int'(Valid), 0);
    check("rst Busy", int'(Busy), 0);
    check("rst Timeout", int'(Timeout), 0);
    check("rst PeriodCount8", int'(PeriodCount8), 0);
    Rst = 1'b0;
    tick(2);

    for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Start during MEASURE and during the DONE cycle is ignored.
    SignalIn = 1'b0;
    tick(4);
    v0 = v_cnt;
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
    tick(2);
    SignalIn = 1'b1;
    tick(10);
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
    tick(14);
    SignalIn = 1'b0;
    tick(75);
    SignalIn = 1'b1;
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      tick(1);
      if (Valid) found = 1;
    end
    check("ign valid_seen", found, 1);
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
    tick(24);
    SignalIn = 1'b0;
    tick(75);
    wave(100, 25, 2);
    tick(8);
    check("ign valid_count", v_cnt - v0, 1);
    check("ign period", int'(PeriodCount), 100);
    check("ign high", int'(HighCount), 25);
    check("ign busy", int'(Busy), 0);

    // Narrow counter: one good result, then a timeout that must keep it.
    SignalIn = 1'b0;
    tick(4);
    v0 = v8_cnt;
    Start8 = 1'b1;
    tick(1);
    Start8 = 1'b0;
    tick(2);
    wave(20, 5, 2);
    tick(8);
    check("n8 valid_count", v8_cnt - v0, 1);
    check("n8 period", cap8_per, 20);
    check("n8 high", cap8_high, 5);

    v0 = v8_cnt;
    t0 = t8_cnt;
    Start8 = 1'b1;
    tick(1);
    Start8 = 1'b0;
    tick(300);
    check("to_low count", t8_cnt - t0, 1);
    check("to_low latency", to8_cyc - busy8_rise, 255);
    check("to_low valid", v8_cnt - v0, 0);
    check("to_low busy", int'(Busy8), 0);
    check("to_low period_kept", int'(PeriodCount8), 20);
    check("to_low high_kept", int'(HighCount8), 5);

    // DC high input also times out.
    SignalIn = 1'b1;
    tick(5);
    t0 = t8_cnt;
    Start8 = 1'b1;
    tick(1);
    Start8 = 1'b0;
    tick(300);
    check("to_high count", t8_cnt - t0, 1);
    check("to_high valid", v8_cnt - v0, 0);
    SignalIn = 1'b0;
    tick(5);

    // Edge arriving on the threshold cycle: timeout wins.
    t0 = t8_cnt;
    Start8 = 1'b1;
    tick(1);
    Start8 = 1'b0;
    tick(252);
    SignalIn = 1'b1;
    tick(10);
    SignalIn = 1'b0;
    check("to_edge count", t8_cnt - t0, 1);
    check("to_edge latency", to8_cyc - busy8_rise, 255);
    check("to_edge valid", v8_cnt - v0, 0);
    check("to_edge busy", int'(Busy8), 0);
    tick(5);

    // Reset mid-MEASURE discards the measurement and clears the outputs.
    v0 = v_cnt;
    t0 = t_cnt;
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
    tick(2);
    SignalIn = 1'b1;
    tick(30);
    SignalIn = 1'b0;
    #2 Rst = 1'b1;
    #1;
    check("rstmid PeriodCount", int'(PeriodCount), 0);
    check("rstmid HighCount", int'(HighCount), 0);
    check("rstmid Busy", int'(Busy), 0);
    tick(2);
    Rst = 1'b0;
    wave(40, 12, 3);
    tick(8);
    check("rstmid valid", v_cnt - v0, 0);
    check("rstmid timeout", t_cnt - t0, 0);
    run_vec("after_rst", '{40, 12, 2'd1, 80, 24});

    // Asynchronous phase sweep, period 64 high 32 clocks.
    for (int i = 0; i < 20; i++) begin
      SignalIn = 1'b0;
      tick(4);
      v0 = v_cnt;
      Start = 1'b1;
      tick(1);
      Start = 1'b0;
      #(i * 4 + 3);
      repeat (3) begin
        SignalIn = 1'b1;
        #3200;
        SignalIn = 1'b0;
        #3200;
      end
      tick(6);
      check($sformatf("phase%0d valid", i), v_cnt - v0, 1);
      check_range($sformatf("phase%0d period", i), cap_per, 63, 65);
      check_range($sformatf("phase%0d high", i), cap_high, 31, 33);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "time limit");
  end

endmodule
